instruction_fetch: RTL
======================

# instruction_fetch

Instruction fetch stage driving the instruction side of the shared single-port memory selector. Holds the program counter and issues one word read per instruction slot granted by the selector. Captures the returned word into a small FIFO and presents it to decode with a valid/ready handshake. Supports a one-cycle redirect (branch/jump) that flushes everything in flight.

## Interface
- `ADDR_W`, 8: word address width; matches the selector's `mem_addr_instr`.
- `DATA_W`, 32: instruction width.
- `RESET_PC`, 0: PC value loaded on reset.
- `FIFO_DEPTH`, 2: fetch buffer entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock for the block; all state updates on its rising edge.
- `reset`  in  1  reset, synchronous and active-high.
- `instr_slot`  in  1  high in cycles where the selector routes the shared port to the instruction side.
- `mem_addr_instr`  out  ADDR_W  read address (current PC).
- `mem_read_en_instr`  out  1  read request for this cycle.
- `mem_read_val_instr`  in  DATA_W  read data; valid in the same cycle as an accepted request (combinational memory read).
- `redirect_en`  in  1  load new PC and flush.
- `redirect_pc`  in  ADDR_W  redirect target.
- `instr_valid`  out  1  FIFO head is valid.
- `instr_ready`  in  1  decode accepts head this cycle.
- `instr_out`  out  DATA_W  head instruction.
- `instr_pc`  out  ADDR_W  address the head instruction was fetched from.

## Operation
- `pc` register, word-addressed, +1 per fetch, wraps 255→0 (mod 2^ADDR_W).
- `space` = (count < FIFO_DEPTH) or (count == FIFO_DEPTH and pop this cycle).
- `pop` = `instr_valid & instr_ready`.
- `mem_read_en_instr` = `instr_slot & space & ~redirect_en & ~reset` (combinational).
- `mem_addr_instr` = `pc` at all times.
- Fetch cycle, when `mem_read_en_instr` is high: push {`pc`, `mem_read_val_instr`} into the FIFO; `pc <= pc + 1`.
- Simultaneous push and pop: both occur; count is unchanged.
- Pop on an empty FIFO is impossible, because `instr_valid` is low.
- Redirect has priority over everything:
  - FIFO is cleared (count 0); any pop in that cycle is discarded, not delivered.
  - `pc <= redirect_pc`.
  - No fetch occurs in the redirect cycle.
- `instr_out` and `instr_pc` are stable while `instr_valid & ~instr_ready`, absent redirect.
- When the FIFO is empty, `instr_out` and `instr_pc` retain the last head-slot contents; decode ignores them.

## Timing
- Reset values:
  - `pc = RESET_PC`, FIFO count 0.
  - `instr_valid = 0`, `instr_out = 0`, `instr_pc = 0`.
  - `mem_read_en_instr = 0`; `mem_addr_instr = RESET_PC`.
- Reset overrides redirect and fetch in the same cycle. Reset mid-stream discards all buffered words.
- Latency: word fetched in slot cycle N; `instr_valid` is high in cycle N+1 (registered FIFO head).
- Throughput: at most one fetch per two cycles (selector alternates slots). No fetch issues outside `instr_slot`.
- Redirect in cycle N: `pc = redirect_pc` and FIFO empty from N+1. The first new word is fetched in the first `instr_slot` cycle ≥ N+1.
- Full FIFO with `instr_ready` low: no requests and PC frozen until a pop frees space. A pop in the same slot cycle counts as space.

## Structure
- Shared package `fetch_pkg`:
  - constants `ADDR_W`, `DATA_W`, `RESET_PC`;
  - typedef `fetch_entry_t` {pc[ADDR_W], instr[DATA_W]}.
- Sub-module `fetch_buffer`:
  - synchronous FIFO of `fetch_entry_t`, FIFO_DEPTH entries;
  - ports `push`, `pop`, `flush`, `full`, `empty`, head output;
  - circular read/write pointers plus a count.
- The top level holds only the PC, request logic and redirect priority.

## Test plan
- Reset then free run: `instr_slot` toggles, `instr_ready=1`, memory word[i]=0x1000_0000+i. Deliveries are pc 0,1,2,3 with matching data; `instr_valid` rises the cycle after the first slot.
- Backpressure: `instr_ready=0` for 10 cycles. Exactly 2 words buffered (pc 0,1), then `mem_read_en_instr` stays low and `pc` holds 2. Releasing ready delivers 0,1,2 in order with no loss or duplicate.
- Redirect: with 2 entries buffered, pulse `redirect_en` with `redirect_pc=0x40`. Next cycle `instr_valid=0`; the next delivered word is pc 0x40/data 0x1000_0040; pc 0x02 is never delivered.
- Redirect and pop coincide in a slot cycle: there is no fetch that cycle and the popped entry is not counted as delivered by the scoreboard.
- Wrap: redirect to 0xFE. Delivered pcs are 0xFE, 0xFF, 0x00, 0x01.
- Reset asserted mid-stream with 1 entry buffered: next cycle `instr_valid=0` and `pc=RESET_PC`; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared constants and types for the instruction fetch stage.
//   ADDR_W        word address width of the instruction port
//   DATA_W        instruction width
//   RESET_PC      program counter value loaded on reset
//   FIFO_DEPTH    default fetch buffer depth (power of two, >= 2)
//   fetch_entry_t one buffered fetch: the PC it came from and the word read
// ---------------------------------------------------------------------------
package fetch_pkg;

   localparam int unsigned ADDR_W     = 8;
   localparam int unsigned DATA_W     = 32;
   localparam logic [ADDR_W-1:0] RESET_PC = '0;
   localparam int unsigned FIFO_DEPTH = 2;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] instr;
   } fetch_entry_t;

endpackage : fetch_pkg

// File: rtl/instruction_fetch_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_if
// Groups the fetch stage's bus signals: the instruction side of the shared
// memory selector, the redirect request and the decode handshake.
//   master modport : the fetch stage
//   slave  modport : selector/memory, branch unit and decode
// Signals:
//   instr_slot          selector grants the shared port to instruction side
//   mem_addr_instr      read address (current PC)
//   mem_read_en_instr   read request this cycle
//   mem_read_val_instr  combinational read data for an accepted request
//   redirect_en/_pc     load new PC and flush everything in flight
//   instr_valid/_ready  decode handshake on the buffer head
//   instr_out/_pc       head instruction and the address it came from
// ---------------------------------------------------------------------------
interface instruction_fetch_if;
   import fetch_pkg::*;

   logic              instr_slot;
   logic [ADDR_W-1:0] mem_addr_instr;
   logic              mem_read_en_instr;
   logic [DATA_W-1:0] mem_read_val_instr;
   logic              redirect_en;
   logic [ADDR_W-1:0] redirect_pc;
   logic              instr_valid;
   logic              instr_ready;
   logic [DATA_W-1:0] instr_out;
   logic [ADDR_W-1:0] instr_pc;

   modport master (
      input  instr_slot,
      input  mem_read_val_instr,
      input  redirect_en,
      input  redirect_pc,
      input  instr_ready,
      output mem_addr_instr,
      output mem_read_en_instr,
      output instr_valid,
      output instr_out,
      output instr_pc
   );

   modport slave (
      output instr_slot,
      output mem_read_val_instr,
      output redirect_en,
      output redirect_pc,
      output instr_ready,
      input  mem_addr_instr,
      input  mem_read_en_instr,
      input  instr_valid,
      input  instr_out,
      input  instr_pc
   );

endinterface : instruction_fetch_if

// File: rtl/fetch_buffer.sv
// ---------------------------------------------------------------------------
// fetch_buffer
// Synchronous FIFO of fetch_entry_t with circular read/write pointers and an
// occupancy count. The head is read straight from the storage registers, so
// an entry pushed in cycle N is visible at the head in cycle N+1.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   push         write push_entry this cycle
//   push_entry   entry to write
//   pop          drop the head this cycle (never asserted while empty)
//   flush        discard all entries; overrides push and pop
//   full, empty  occupancy flags
//   head         current head entry (last head-slot contents when empty)
// ---------------------------------------------------------------------------
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = FIFO_DEPTH
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  fetch_entry_t push_entry,
   input  logic         pop,
   input  logic         flush,
   output logic         full,
   output logic         empty,
   output fetch_entry_t head
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      if (flush) begin
         // Keep the read pointer so the head port holds its last contents.
         wr_ptr_d = rd_ptr_q;
         cnt_d    = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         if (push && !flush) mem_q[wr_ptr_q] <= push_entry;
      end
   end

   assign full  = (cnt_q == CNT_W'(DEPTH));
   assign empty = (cnt_q == '0);
   assign head  = mem_q[rd_ptr_q];

endmodule : fetch_buffer

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
// Fetch stage: holds the PC, issues one read per granted instruction slot
// when the buffer has room, and hands buffered words to decode.
// Redirect beats fetch and pop; reset beats everything.
// Parameters:
//   FIFO_DEPTH   fetch buffer entries (power of two, >= 2)
// Ports:
//   clk          single clock, all state on its rising edge
//   reset        synchronous active-high reset
//   fif          instruction_fetch_if.master (memory, redirect, decode)
// ---------------------------------------------------------------------------
module instruction_fetch
   import fetch_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = fetch_pkg::FIFO_DEPTH
) (
   input  logic                clk,
   input  logic                reset,
   instruction_fetch_if.master fif
);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              buf_full;
   logic              buf_empty;
   logic              pop;
   logic              space;
   logic              fetch;
   fetch_entry_t      push_entry;
   fetch_entry_t      head;

   assign pop   = fif.instr_valid & fif.instr_ready;
   // A full buffer still accepts a word when its head leaves this cycle.
   assign space = ~buf_full | pop;
   assign fetch = fif.instr_slot & space & ~fif.redirect_en & ~reset;

   assign push_entry.pc    = pc_q;
   assign push_entry.instr = fif.mem_read_val_instr;

   always_comb begin
      pc_d = pc_q;
      if (fif.redirect_en) pc_d = fif.redirect_pc;
      else if (fetch)      pc_d = pc_q + ADDR_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) pc_q <= RESET_PC;
      else       pc_q <= pc_d;
   end

   fetch_buffer #(
      .DEPTH (FIFO_DEPTH)
   ) u_buf (
      .clk        (clk),
      .reset      (reset),
      .push       (fetch),
      .push_entry (push_entry),
      .pop        (pop & ~fif.redirect_en),
      .flush      (fif.redirect_en),
      .full       (buf_full),
      .empty      (buf_empty),
      .head       (head)
   );

   assign fif.mem_addr_instr    = pc_q;
   assign fif.mem_read_en_instr = fetch;
   assign fif.instr_valid       = ~buf_empty;
   assign fif.instr_out         = head.instr;
   assign fif.instr_pc          = head.pc;

endmodule : instruction_fetch
